// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // FSM state encoding (2 bits)
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH_LO = 2'd1,
    ST_FETCH_HI = 2'd2,
    ST_DATA     = 2'd3
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;

  // Registered bus-side request fields, loaded on grant
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        cmd;
    logic        be1;
    logic        be0;
  } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, LSU and external memory bus signals of the memory port arbiter.
// master = arbiter view, slave = core/memory environment view.
interface mem_port_arbiter_if;
  // fetch side
  logic        if_req;
  logic [15:0] if_pc;
  logic        if_flush;
  logic        if_rdy;
  logic [31:0] if_opcode;
  // LSU side
  logic        d_req_assert;
  logic [15:0] d_req_addr;
  logic [15:0] d_req_data;
  logic        d_req_cmd;
  logic        d_req_be0;
  logic        d_req_be1;
  logic        d_rdy;
  logic [15:0] d_data_in;
  // external memory bus
  logic [15:0] bus_addr;
  logic [15:0] bus_data_out;
  logic        bus_cmd;
  logic        bus_be0;
  logic        bus_be1;
  logic        bus_assert;
  logic        bus_rdy;
  logic [15:0] bus_data_in;

  modport master (
    input  if_req, if_pc, if_flush,
    input  d_req_assert, d_req_addr, d_req_data, d_req_cmd, d_req_be0, d_req_be1,
    input  bus_rdy, bus_data_in,
    output if_rdy, if_opcode, d_rdy, d_data_in,
    output bus_addr, bus_data_out, bus_cmd, bus_be0, bus_be1, bus_assert
  );

  modport slave (
    output if_req, if_pc, if_flush,
    output d_req_assert, d_req_addr, d_req_data, d_req_cmd, d_req_be0, d_req_be1,
    output bus_rdy, bus_data_in,
    input  if_rdy, if_opcode, d_rdy, d_data_in,
    input  bus_addr, bus_data_out, bus_cmd, bus_be0, bus_be1, bus_assert
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory bus between two-beat instruction fetch and the
// LSU data port. Data has priority; a starvation counter forces a fetch
// after STARVE_LIMIT consecutive data grants while fetch is waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             a_rst,
  mem_port_arbiter_if.master port
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  bus_req_t         bus_q;
  logic             bus_assert_q;
  logic [15:0]      pc_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             flush_pend;
  logic             if_rdy_q;
  logic [31:0]      opcode_q;

  logic beat_done;
  logic fetch_req;
  logic starved;
  logic grant_data;
  logic grant_fetch;

  // A beat completes whenever the bus is driven and memory is ready.
  assign beat_done = bus_assert_q & port.bus_rdy;
  // if_req is still high in the if_rdy cycle; masking it there avoids
  // fetching the same opcode twice.
  assign fetch_req   = port.if_req & ~if_rdy_q;
  assign starved     = (starve_cnt >= LIMIT);
  assign grant_data  = port.d_req_assert & (~fetch_req | ~starved);
  assign grant_fetch = fetch_req & ~grant_data;

  // Arbitration FSM, bus output registers, opcode assembly, starvation count
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state        <= ST_IDLE;
      bus_q        <= '0;
      bus_assert_q <= 1'b0;
      pc_q         <= '0;
      starve_cnt   <= '0;
      flush_pend   <= 1'b0;
      if_rdy_q     <= 1'b0;
      opcode_q     <= '0;
    end else begin
      if_rdy_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          flush_pend <= 1'b0;
          if (grant_data) begin
            state        <= ST_DATA;
            bus_assert_q <= 1'b1;
            bus_q        <= '{addr: port.d_req_addr, data: port.d_req_data,
                              cmd: port.d_req_cmd, be1: port.d_req_be1,
                              be0: port.d_req_be0};
            if (!fetch_req)    starve_cnt <= '0;
            else if (!starved) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_fetch) begin
            state        <= ST_FETCH_LO;
            bus_assert_q <= 1'b1;
            pc_q         <= port.if_pc;
            bus_q        <= '{addr: port.if_pc, data: 16'h0000, cmd: CMD_READ,
                              be1: 1'b1, be0: 1'b1};
            starve_cnt   <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_FETCH_LO: begin
          if (port.if_flush) flush_pend <= 1'b1;
          if (beat_done) begin
            opcode_q[15:0] <= port.bus_data_in;
            bus_q.addr     <= pc_q + 16'd1;
            state          <= ST_FETCH_HI;
          end
        end
        ST_FETCH_HI: begin
          if (beat_done) begin
            opcode_q[31:16] <= port.bus_data_in;
            bus_assert_q    <= 1'b0;
            state           <= ST_IDLE;
            // a redirect arriving on the final beat also kills the result
            if_rdy_q        <= ~(flush_pend | port.if_flush);
            flush_pend      <= 1'b0;
          end else if (port.if_flush) begin
            flush_pend <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat_done) begin
            bus_assert_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign port.bus_addr     = bus_q.addr;
  assign port.bus_data_out = bus_q.data;
  assign port.bus_cmd      = bus_q.cmd;
  assign port.bus_be0      = bus_q.be0;
  assign port.bus_be1      = bus_q.be1;
  assign port.bus_assert   = bus_assert_q;
  assign port.if_rdy       = if_rdy_q;
  assign port.if_opcode    = opcode_q;
  assign port.d_rdy        = beat_done & (state == ST_DATA);
  assign port.d_data_in    = port.bus_data_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bif();

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .a_rst(a_rst), .port(bif)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // physical memory behind the bus, and the model view of memory
  logic [15:0] pmem [logic [15:0]];
  logic [15:0] mmem [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
  endfunction
  function automatic logic [15:0] prd(input logic [15:0] a);
    return pmem.exists(a) ? pmem[a] : dflt(a);
  endfunction
  function automatic logic [15:0] mrd(input logic [15:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic be0, input logic be1);
    return {be1 ? d[15:8] : old[15:8], be0 ? d[7:0] : old[7:0]};
  endfunction

  task automatic bus_mem_write();
    if (bif.bus_assert && bif.bus_rdy && bif.bus_cmd == CMD_WRITE)
      pmem[bif.bus_addr] = merge(prd(bif.bus_addr), bif.bus_data_out, bif.bus_be0, bif.bus_be1);
  endtask

  task automatic clear_inputs();
    bif.if_req = 0; bif.if_pc = '0; bif.if_flush = 0;
    bif.d_req_assert = 0; bif.d_req_addr = '0; bif.d_req_data = '0;
    bif.d_req_cmd = 0; bif.d_req_be0 = 0; bif.d_req_be1 = 0;
    bif.bus_rdy = 0; bif.bus_data_in = '0;
  endtask

  typedef struct {
    logic        is_fetch;
    logic [15:0] addr;
    logic        cmd;
    logic        be0;
    logic        be1;
    logic [15:0] wdata;
    int          waits;
    logic [31:0] exp_res;   // opcode or read data
    int          exp_lat;   // cycle index of if_rdy / d_rdy, request cycle = 0
    int          exp_act;   // cycles with bus_assert high
  } vec_t;

  // one isolated transaction with a fixed number of wait states per beat
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, wcnt, beat, act, lat;
    logic done;
    logic [15:0] ea;
    @(negedge clk);
    if (v.is_fetch) begin
      bif.if_req = 1; bif.if_pc = v.addr;
    end else begin
      bif.d_req_assert = 1; bif.d_req_addr = v.addr; bif.d_req_data = v.wdata;
      bif.d_req_cmd = v.cmd; bif.d_req_be0 = v.be0; bif.d_req_be1 = v.be1;
    end
    cyc = 0; wcnt = 0; beat = 0; act = 0; lat = -1; done = 0;
    while (!done && cyc < 40) begin
      if (v.is_fetch && bif.if_rdy) begin
        chk({tag, "_opcode"}, bif.if_opcode, v.exp_res);
        lat = cyc; done = 1;
      end
      bif.bus_rdy = 0;
      if (bif.bus_assert) begin
        act++;
        ea = v.is_fetch ? v.addr + 16'(beat) : v.addr;
        chk({tag, "_bus_addr"}, bif.bus_addr, ea);
        chk({tag, "_bus_cmd"}, bif.bus_cmd, v.is_fetch ? CMD_READ : v.cmd);
        chk({tag, "_bus_be"}, {bif.bus_be1, bif.bus_be0}, v.is_fetch ? 2'b11 : {v.be1, v.be0});
        if (!v.is_fetch && v.cmd == CMD_WRITE)
          chk({tag, "_bus_wdata"}, bif.bus_data_out, v.wdata);
        bif.bus_rdy = (wcnt == v.waits);
        if (bif.bus_rdy) begin wcnt = 0; beat++; end
        else wcnt++;
      end
      bif.bus_data_in = prd(bif.bus_addr);
      #1;
      bus_mem_write();
      if (!v.is_fetch && bif.d_rdy) begin
        if (v.cmd == CMD_READ) chk({tag, "_rdata"}, bif.d_data_in, v.exp_res);
        lat = cyc; done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_assert_cycles"}, act, v.exp_act);
    chk({tag, "_idle_after"}, bif.bus_assert, 1'b0);
    @(negedge clk);
    chk({tag, "_no_reissue"}, bif.bus_assert, 1'b0);
  endtask

  vec_t vecs [6];

  initial begin
    int ndata, cyc, hi_wait;
    logic fetch_seen, got_rdy, saw_rdy, done;
    logic [15:0] st_addr;
    // randomized-run state
    logic f_live, d_live, d_cmd, d_be0, d_be1, issue;
    logic [15:0] f_pc, d_addr, d_wdata;
    int f_age, max_f_age, consec, max_consec, n_fetch, n_data;

    vecs[0] = '{1'b1, 16'h1230, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'hCAFEBEEF, 3, 2};
    vecs[1] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'h22221111, 3, 2};
    vecs[2] = '{1'b0, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0000, 2, 32'h000055AA, 3, 3};
    vecs[3] = '{1'b0, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h1234, 0, 32'h00000000, 1, 1};
    vecs[4] = '{1'b0, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 32'h00005534, 2, 2};
    vecs[5] = '{1'b1, 16'h1230, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 32'hCAFEBEEF, 5, 4};

    pmem[16'h1230] = 16'hBEEF; pmem[16'h1231] = 16'hCAFE;
    pmem[16'hFFFF] = 16'h1111; pmem[16'h0000] = 16'h2222;
    pmem[16'h0040] = 16'h55AA;

    // reset state
    clear_inputs();
    a_rst = 1;
    repeat (3) @(negedge clk);
    a_rst = 0;
    chk("rst_bus_assert", bif.bus_assert, 1'b0);
    chk("rst_if_rdy", bif.if_rdy, 1'b0);
    chk("rst_d_rdy", bif.d_rdy, 1'b0);
    chk("rst_opcode", bif.if_opcode, 32'h0);
    chk("rst_bus_fields", {bif.bus_addr, bif.bus_data_out, bif.bus_cmd, bif.bus_be1, bif.bus_be0}, 35'h0);
    chk("rst_starve", dut.starve_cnt, 3'd0);
    chk("rst_state", dut.state, ST_IDLE);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // contention: fetch held against back-to-back stores
    @(negedge clk);
    bif.if_req = 1; bif.if_pc = 16'h2000;
    st_addr = 16'h0100;
    bif.d_req_assert = 1; bif.d_req_addr = st_addr; bif.d_req_data = 16'($urandom);
    bif.d_req_cmd = CMD_WRITE; bif.d_req_be0 = 1; bif.d_req_be1 = 1;
    ndata = 0; fetch_seen = 0; got_rdy = 0; cyc = 0;
    while (!got_rdy && cyc < 80) begin
      if (bif.if_rdy) begin
        chk("contend_opcode", bif.if_opcode, {prd(16'h2001), prd(16'h2000)});
        got_rdy = 1; bif.if_req = 0; bif.d_req_assert = 0;
      end
      bif.bus_rdy = bif.bus_assert;
      bif.bus_data_in = prd(bif.bus_addr);
      if (bif.bus_assert && bif.bus_cmd == CMD_READ && !fetch_seen) begin
        fetch_seen = 1;
        chk("contend_data_grants", ndata, 4);
        chk("contend_starve_clr", dut.starve_cnt, 3'd0);
      end
      #1;
      bus_mem_write();
      if (bif.d_rdy) begin
        ndata++;
        st_addr++;
        bif.d_req_addr = st_addr; bif.d_req_data = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("contend_fetch_done", got_rdy, 1'b1);
    clear_inputs();
    repeat (2) @(negedge clk);

    // flush during the high-beat wait state
    bif.if_req = 1; bif.if_pc = 16'h1230;
    saw_rdy = 0; hi_wait = 0; done = 0; cyc = 0;
    while (!done && cyc < 30) begin
      if (bif.if_rdy) saw_rdy = 1;
      bif.bus_rdy = 0;
      if (bif.bus_assert) begin
        if (bif.bus_addr == 16'h1231) begin
          if (hi_wait < 2) begin
            bif.if_flush = (hi_wait == 0);
            if (hi_wait == 0) bif.if_req = 0;
            hi_wait++;
          end else begin
            bif.if_flush = 0; bif.bus_rdy = 1; done = 1;
          end
        end else bif.bus_rdy = 1;
      end
      bif.bus_data_in = prd(bif.bus_addr);
      @(negedge clk);
      cyc++;
    end
    chk("flush_beat_done", done, 1'b1);
    chk("flush_bus_released", bif.bus_assert, 1'b0);
    chk("flush_state_idle", dut.state, ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      if (bif.if_rdy) saw_rdy = 1;
      @(negedge clk);
    end
    chk("flush_no_if_rdy", saw_rdy, 1'b0);
    chk("flush_pend_clr", dut.flush_pend, 1'b0);
    run_vec(vecs[1], "post_flush");

    // reset in the middle of a data wait state
    @(negedge clk);
    bif.if_req = 1; bif.if_pc = 16'h3000;
    bif.d_req_assert = 1; bif.d_req_addr = 16'h0040; bif.d_req_cmd = CMD_READ;
    bif.d_req_be0 = 1; bif.d_req_be1 = 1; bif.bus_rdy = 0;
    cyc = 0;
    while (!bif.bus_assert && cyc < 5) begin @(negedge clk); cyc++; end
    chk("rstmid_granted", bif.bus_assert, 1'b1);
    chk("rstmid_starve_pre", dut.starve_cnt, 3'd1);
    @(negedge clk);
    a_rst = 1; bif.if_req = 0; bif.d_req_assert = 0;
    @(negedge clk);
    a_rst = 0; bif.bus_rdy = 1;
    #1;
    chk("rstmid_bus_assert", bif.bus_assert, 1'b0);
    chk("rstmid_d_rdy", bif.d_rdy, 1'b0);
    chk("rstmid_state", dut.state, ST_IDLE);
    chk("rstmid_starve", dut.starve_cnt, 3'd0);
    @(negedge clk);
    chk("rstmid_stays_idle", bif.bus_assert, 1'b0);
    clear_inputs();

    // randomized traffic against the transaction-level model
    mmem = pmem;
    f_live = 0; d_live = 0; f_pc = '0; d_addr = '0; d_wdata = '0;
    d_cmd = 0; d_be0 = 0; d_be1 = 0;
    f_age = 0; max_f_age = 0; consec = 0; max_consec = 0; n_fetch = 0; n_data = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      issue = (c < 1500);
      bif.if_flush = 0;
      if (bif.if_rdy) begin
        chk("rnd_if_rdy_expected", bif.if_rdy, f_live);
        if (f_live) begin
          chk("rnd_opcode", bif.if_opcode, {mrd(f_pc + 16'd1), mrd(f_pc)});
          n_fetch++;
        end
        f_live = 0; bif.if_req = 0; consec = 0;
      end else if (f_live && $urandom_range(0, 29) == 0) begin
        bif.if_flush = 1; bif.if_req = 0; f_live = 0; consec = 0;
      end else if (!f_live && issue && $urandom_range(0, 2) == 0) begin
        f_pc = 16'hFFF8 + 16'($urandom_range(0, 15));
        bif.if_req = 1; bif.if_pc = f_pc; f_live = 1; f_age = 0; consec = 0;
      end
      if (f_live) begin
        f_age++;
        if (f_age > max_f_age) max_f_age = f_age;
      end
      bif.bus_rdy = ($urandom_range(0, 2) != 0);
      bif.bus_data_in = prd(bif.bus_addr);
      if (!d_live && issue && $urandom_range(0, 1) == 0) begin
        d_addr = 16'hFFF8 + 16'($urandom_range(0, 15));
        d_cmd = 1'($urandom_range(0, 1));
        d_be0 = 1'($urandom_range(0, 1)); d_be1 = 1'($urandom_range(0, 1));
        d_wdata = 16'($urandom);
        d_live = 1;
      end
      bif.d_req_assert = d_live; bif.d_req_addr = d_addr; bif.d_req_data = d_wdata;
      bif.d_req_cmd = d_cmd; bif.d_req_be0 = d_be0; bif.d_req_be1 = d_be1;
      #1;
      bus_mem_write();
      if (bif.d_rdy) begin
        chk("rnd_d_rdy_expected", bif.d_rdy, d_live);
        if (d_live) begin
          chk("rnd_data_addr", bif.bus_addr, d_addr);
          if (d_cmd == CMD_READ) chk("rnd_rdata", bif.d_data_in, mrd(d_addr));
          else mmem[d_addr] = merge(mrd(d_addr), d_wdata, d_be0, d_be1);
          n_data++;
          if (f_live) begin
            consec++;
            if (consec > max_consec) max_consec = consec;
          end
        end
        d_live = 0;
      end
    end
    chk("rnd_fetch_drained", f_live, 1'b0);
    chk("rnd_data_drained", d_live, 1'b0);
    chk("rnd_starve_bound", max_consec <= 5, 1'b1);
    chk("rnd_fetch_age_bound", max_f_age <= 300, 1'b1);
    chk("rnd_fetch_activity", n_fetch > 10, 1'b1);
    chk("rnd_data_activity", n_data > 10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
